// File: rtl/consec_mon_pkg.sv
// Shared types for the consecutive-grant monitor.
//   chk_state_e : per-channel FSM state (idle, pre-sample delay, run, strict tail)
//   fail_code_e : reason reported alongside a fail pulse
package consec_mon_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDelay = 2'd1,
        StRun   = 2'd2,
        StTail  = 2'd3
    } chk_state_e;

    typedef enum logic [1:0] {
        FcNone    = 2'd0,
        FcNoStart = 2'd1,
        FcShort   = 2'd2,
        FcLong    = 2'd3
    } fail_code_e;

    // Run counter must hold MAX_REP+1 (up to 256).
    localparam int unsigned RUN_W = 9;

endpackage

// File: rtl/grant_run_chk.sv
// Single-channel consecutive-grant checker.
// After an accepted req, waits DELAY cycles, then expects grant high for at least
// MIN_REP consecutive samples (and at most MAX_REP when strict was set at start).
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   en, strict       : accept enable, strict mode (latched at attempt start)
//   req, grant       : request and grant for this channel
//   busy             : attempt in progress
//   pass_o, fail_o   : one-cycle verdict pulses, fail_code valid with fail_o
//   drop_o           : one-cycle pulse for a req ignored while busy
//   pass_cnt/fail_cnt: saturating verdict counters
module grant_run_chk
    import consec_mon_pkg::*;
#(
    parameter int unsigned DELAY   = 1,
    parameter int unsigned MIN_REP = 3,
    parameter int unsigned MAX_REP = 5,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             strict,
    input  logic             req,
    input  logic             grant,
    output logic             busy,
    output logic             pass_o,
    output logic             fail_o,
    output logic [1:0]       fail_code,
    output logic             drop_o,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    localparam logic [3:0]       DLY_INIT = (DELAY > 0) ? 4'(DELAY - 1) : 4'd0;
    localparam logic [RUN_W-1:0] MIN_L    = RUN_W'(MIN_REP);
    localparam logic [RUN_W-1:0] LONG_L   = RUN_W'(MAX_REP + 1);

    chk_state_e       state_q;
    logic [3:0]       dly_q;
    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_inc;
    logic             strict_q;
    logic             pass_q, fail_q, drop_q;
    fail_code_e       code_q;
    logic [CNT_W-1:0] pass_cnt_q, fail_cnt_q;

    logic       pass_d, fail_d;
    fail_code_e code_d;

    assign run_inc = run_q + RUN_W'(1);

    // Verdict decode for the current grant sample.
    always_comb begin
        pass_d = 1'b0;
        fail_d = 1'b0;
        code_d = FcNone;
        unique case (state_q)
            StRun: begin
                if (!grant) begin
                    fail_d = 1'b1;
                    code_d = (run_q == '0) ? FcNoStart : FcShort;
                end else if (run_inc == MIN_L && !strict_q) begin
                    pass_d = 1'b1;
                end
            end
            StTail: begin
                if (!grant) begin
                    pass_d = 1'b1;
                end else if (run_inc == LONG_L) begin
                    fail_d = 1'b1;
                    code_d = FcLong;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            dly_q    <= '0;
            run_q    <= '0;
            strict_q <= 1'b0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
            code_q   <= FcNone;
            drop_q   <= 1'b0;
        end else begin
            pass_q <= pass_d;
            fail_q <= fail_d;
            code_q <= code_d;
            // The deciding edge still counts as busy, so a req there is dropped.
            drop_q <= req && (state_q != StIdle);
            unique case (state_q)
                StIdle: begin
                    if (req && en) begin
                        strict_q <= strict;
                        run_q    <= '0;
                        dly_q    <= DLY_INIT;
                        state_q  <= (DELAY == 0) ? StRun : StDelay;
                    end
                end
                StDelay: begin
                    if (dly_q == 4'd0) state_q <= StRun;
                    else               dly_q   <= dly_q - 4'd1;
                end
                StRun: begin
                    if (pass_d || fail_d) begin
                        state_q <= StIdle;
                    end else begin
                        run_q <= run_inc;
                        if (run_inc == MIN_L) state_q <= StTail;
                    end
                end
                StTail: begin
                    if (pass_d || fail_d) state_q <= StIdle;
                    else                  run_q   <= run_inc;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            if (pass_d && pass_cnt_q != '1) pass_cnt_q <= pass_cnt_q + CNT_W'(1);
            if (fail_d && fail_cnt_q != '1) fail_cnt_q <= fail_cnt_q + CNT_W'(1);
        end
    end

    assign busy      = (state_q != StIdle);
    assign pass_o    = pass_q;
    assign fail_o    = fail_q;
    assign fail_code = code_q;
    assign drop_o    = drop_q;
    assign pass_cnt  = pass_cnt_q;
    assign fail_cnt  = fail_cnt_q;

endmodule

// File: rtl/consec_grant_monitor.sv
// Multi-channel consecutive-grant monitor: NUM_CH independent grant_run_chk instances.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   en, strict          : global accept enable, strict (MAX_REP) mode
//   req, grant          : per-channel request / grant vectors
//   busy, pass_o, fail_o, drop_o : per-channel status and one-cycle pulses
//   fail_code           : 2 bits per channel, valid with fail_o
//   pass_cnt, fail_cnt  : CNT_W bits per channel, saturating
module consec_grant_monitor
    import consec_mon_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned DELAY   = 1,
    parameter int unsigned MIN_REP = 3,
    parameter int unsigned MAX_REP = 5,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    strict,
    input  logic [NUM_CH-1:0]       req,
    input  logic [NUM_CH-1:0]       grant,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       pass_o,
    output logic [NUM_CH-1:0]       fail_o,
    output logic [2*NUM_CH-1:0]     fail_code,
    output logic [NUM_CH-1:0]       drop_o,
    output logic [NUM_CH*CNT_W-1:0] pass_cnt,
    output logic [NUM_CH*CNT_W-1:0] fail_cnt
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        grant_run_chk #(
            .DELAY   (DELAY),
            .MIN_REP (MIN_REP),
            .MAX_REP (MAX_REP),
            .CNT_W   (CNT_W)
        ) u_chk (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .strict    (strict),
            .req       (req[i]),
            .grant     (grant[i]),
            .busy      (busy[i]),
            .pass_o    (pass_o[i]),
            .fail_o    (fail_o[i]),
            .fail_code (fail_code[2*i +: 2]),
            .drop_o    (drop_o[i]),
            .pass_cnt  (pass_cnt[i*CNT_W +: CNT_W]),
            .fail_cnt  (fail_cnt[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_consec_grant_monitor.sv
module tb_consec_grant_monitor;

    localparam int KPass = 0;
    localparam int KFail = 1;
    localparam int KDrop = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        strict;
    logic [3:0]  req;
    logic [3:0]  grant;
    logic [3:0]  busy;
    logic [3:0]  pass_o;
    logic [3:0]  fail_o;
    logic [7:0]  fail_code;
    logic [3:0]  drop_o;
    logic [63:0] pass_cnt;
    logic [63:0] fail_cnt;

    consec_grant_monitor dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .strict    (strict),
        .req       (req),
        .grant     (grant),
        .busy      (busy),
        .pass_o    (pass_o),
        .fail_o    (fail_o),
        .fail_code (fail_code),
        .drop_o    (drop_o),
        .pass_cnt  (pass_cnt),
        .fail_cnt  (fail_cnt)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        int         cyc;
        logic [3:0] p;
        logic [3:0] f;
        logic [3:0] d;
        logic [7:0] c;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Per-test pattern: edges (1-based from the sync point) of req and grant per channel.
    int         rf[4], rl[4], gf[4], gl[4];
    int         en_off_e, strict_off_e;
    logic [3:0] busy_log [0:15];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, want);
            $error("check %s miscompare", tag);
        end
    endtask

    function automatic void expect_ev(int cyc, int ch, int kind, logic [1:0] code);
        exp_t e;
        int   idx;
        idx = -1;
        for (int i = 0; i < sb.size(); i++) if (sb[i].cyc == cyc) idx = i;
        if (idx < 0) begin
            e.cyc = cyc; e.p = '0; e.f = '0; e.d = '0; e.c = '0;
            sb.push_back(e);
            idx = sb.size() - 1;
        end
        e = sb[idx];
        case (kind)
            KPass:   e.p[ch] = 1'b1;
            KFail:   begin e.f[ch] = 1'b1; e.c[2*ch +: 2] = code; end
            default: e.d[ch] = 1'b1;
        endcase
        sb[idx] = e;
    endfunction

    // Pop whatever is expected after the latest edge (nothing -> all pulses low) and compare.
    task automatic check_cycle();
        exp_t        e;
        int          idx;
        logic [19:0] obs, want;
        logic [7:0]  m;
        idx = -1;
        e.cyc = 0; e.p = '0; e.f = '0; e.d = '0; e.c = '0;
        for (int i = 0; i < sb.size(); i++) if (sb[i].cyc == edge_n) idx = i;
        if (idx >= 0) begin
            e = sb[idx];
            sb.delete(idx);
        end
        for (int c = 0; c < 4; c++) m[2*c +: 2] = {2{fail_o[c]}};
        obs  = {pass_o, fail_o, drop_o, fail_code & m};
        want = {e.p, e.f, e.d, e.c};
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $display("FAIL scoreboard cyc=%0d observed(p,f,d,code)=%h expected=%h",
                     edge_n, obs, want);
            $error("scoreboard miscompare");
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic sync(output int b);
        tick();
        b = edge_n;
    endtask

    task automatic clear_pat();
        for (int c = 0; c < 4; c++) begin
            rf[c] = 0; rl[c] = 0; gf[c] = 0; gl[c] = 0;
        end
        en_off_e     = 99;
        strict_off_e = 99;
    endtask

    task automatic apply(input int n);
        for (int e = 1; e <= n; e++) begin
            for (int c = 0; c < 4; c++) begin
                req[c]   = (e >= rf[c] && e <= rl[c]);
                grant[c] = (e >= gf[c] && e <= gl[c]);
            end
            en = (e < en_off_e);
            if (e >= strict_off_e) strict = 1'b0;
            tick();
            busy_log[e] = busy;
        end
        req   = '0;
        grant = '0;
        en    = 1'b1;
    endtask

    int base;

    initial begin
        rst_n  = 1'b1;
        en     = 1'b0;
        strict = 1'b0;
        req    = '0;
        grant  = '0;
        clear_pat();
        #1 rst_n = 1'b0;
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_pulses", 64'({pass_o, fail_o, drop_o, fail_code}), 64'h0);
        chk("rst_pass_cnt", pass_cnt, 64'h0);
        chk("rst_fail_cnt", fail_cnt, 64'h0);
        rst_n = 1'b1;
        en    = 1'b1;

        // Pass at MIN_REP; en drops after acceptance; ch3 req with en=0 is ignored.
        clear_pat();
        rf[0] = 1; rl[0] = 1; gf[0] = 3; gl[0] = 5;
        rf[3] = 3; rl[3] = 3;
        en_off_e = 2;
        sync(base);
        expect_ev(base + 5, 0, KPass, 2'd0);
        apply(7);
        chk("t1_busy_e1", 64'(busy_log[1]), 64'h1);
        chk("t1_busy_e4", 64'(busy_log[4]), 64'h1);
        chk("t1_busy_e5", 64'(busy_log[5]), 64'h0);
        chk("t1_pass_cnt", pass_cnt, 64'h1);

        // Short run.
        clear_pat();
        rf[0] = 1; rl[0] = 1; gf[0] = 3; gl[0] = 4;
        sync(base);
        expect_ev(base + 5, 0, KFail, 2'd2);
        apply(7);
        chk("t2_fail_cnt", fail_cnt, 64'h1);

        // Strict: too long.
        clear_pat();
        strict = 1'b1;
        rf[0] = 1; rl[0] = 1; gf[0] = 3; gl[0] = 9;
        sync(base);
        expect_ev(base + 8, 0, KFail, 2'd3);
        apply(10);
        chk("t3a_busy_tail", 64'(busy_log[7]), 64'h1);
        chk("t3a_fail_cnt", fail_cnt, 64'h2);

        // Strict, input cleared mid-attempt: still evaluated strictly, passes on grant drop.
        clear_pat();
        strict = 1'b1;
        strict_off_e = 2;
        rf[0] = 1; rl[0] = 1; gf[0] = 3; gl[0] = 6;
        sync(base);
        expect_ev(base + 7, 0, KPass, 2'd0);
        apply(9);
        chk("t3b_pass_cnt", pass_cnt, 64'h2);
        strict = 1'b0;

        // Held req: drops while busy (incl. deciding edge), restart once idle.
        clear_pat();
        rf[0] = 1; rl[0] = 6;
        sync(base);
        expect_ev(base + 2, 0, KDrop, 2'd0);
        expect_ev(base + 3, 0, KDrop, 2'd0);
        expect_ev(base + 3, 0, KFail, 2'd1);
        expect_ev(base + 5, 0, KDrop, 2'd0);
        expect_ev(base + 6, 0, KDrop, 2'd0);
        expect_ev(base + 6, 0, KFail, 2'd1);
        apply(8);
        chk("t4_busy_e3", 64'(busy_log[3]), 64'h0);
        chk("t4_busy_e4", 64'(busy_log[4]), 64'h1);
        chk("t4_fail_cnt", fail_cnt, 64'h4);

        // Reset during RUN: attempt abandoned silently.
        clear_pat();
        rf[0] = 1; rl[0] = 1; gf[0] = 3; gl[0] = 9;
        sync(base);
        apply(3);
        chk("t5_busy_run", 64'(busy_log[3]), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", 64'(busy), 64'h0);
        chk("t5_rst_pulses", 64'({pass_o, fail_o, drop_o, fail_code}), 64'h0);
        chk("t5_rst_pass_cnt", pass_cnt, 64'h0);
        chk("t5_rst_fail_cnt", fail_cnt, 64'h0);
        tick();
        rst_n = 1'b1;
        clear_pat();
        rf[0] = 1; rl[0] = 1; gf[0] = 3; gl[0] = 5;
        sync(base);
        expect_ev(base + 5, 0, KPass, 2'd0);
        apply(8);
        chk("t5_fail_cnt_after", fail_cnt, 64'h0);
        chk("t5_pass_cnt_after", pass_cnt, 64'h1);

        // Simultaneous verdicts on three channels, pass counters saturated.
        force dut.g_ch[0].u_chk.pass_cnt_q = 16'hFFFF;
        force dut.g_ch[2].u_chk.pass_cnt_q = 16'hFFFF;
        #1;
        release dut.g_ch[0].u_chk.pass_cnt_q;
        release dut.g_ch[2].u_chk.pass_cnt_q;
        #1;
        chk("t6_preset", pass_cnt, 64'h0000_FFFF_0000_FFFF);
        clear_pat();
        rf[0] = 1; rl[0] = 1; gf[0] = 3; gl[0] = 5;
        rf[2] = 1; rl[2] = 1; gf[2] = 3; gl[2] = 5;
        rf[1] = 3; rl[1] = 3;
        sync(base);
        expect_ev(base + 5, 0, KPass, 2'd0);
        expect_ev(base + 5, 2, KPass, 2'd0);
        expect_ev(base + 5, 1, KFail, 2'd1);
        apply(7);
        chk("t6_pass_cnt_sat", pass_cnt, 64'h0000_FFFF_0000_FFFF);
        chk("t6_fail_cnt", fail_cnt, 64'h0000_0000_0001_0000);

        tick();
        chk("sb_empty", 64'(sb.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
